c7bexu_biu_arb: RTL
===================

C7BEXU_BIU_ARB -- requirements
Module: c7bexu_biu_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- TIMEOUT, 255, bus cycles without bus_ack/bus_err before a forced bus error.
- STARVE_MAX, 4, consecutive LSU grants allowed while IFU is pending.

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- resetn, in, 1, asynchronous active-low reset.
- ifu_req, in, 1, IFU fetch request.
- ifu_addr, in, 32, fetch address.
- ifu_gnt, out, 1, IFU request accepted this cycle.
- ifu_rdata_vld, out, 1, fetch data valid pulse.
- ifu_rdata, out, 32, fetch data.
- ifu_buserr, out, 1, fetch bus-error pulse.
- lsu_req, in, 1, LSU request.
- lsu_we, in, 1, store when 1, load when 0.
- lsu_addr, in, 32, LSU address.
- lsu_wdata, in, 32, store data.
- lsu_wstrb, in, 4, store byte strobes.
- lsu_gnt, out, 1, LSU request accepted.
- lsu_data_valid, out, 1, load data valid pulse.
- lsu_wr_fin, out, 1, store finished pulse.
- lsu_rdata, out, 32, load data.
- lsu_buserr, out, 1, LSU bus-error pulse.
- ecl_flush, in, 1, pipeline flush from the execution control logic.
- bus_req, out, 1, memory port request, held until completion.
- bus_we, out, 1, memory port write enable.
- bus_addr, out, 32, memory port address.
- bus_wdata, out, 32, memory port write data.
- bus_wstrb, out, 4, memory port byte strobes.
- bus_ack, in, 1, slave completion.
- bus_rdata, in, 32, slave read data.
- bus_err, in, 1, slave error completion.

Function
REQ-003 The block shall share the single memory port between IFU and LSU, with one transaction outstanding at most.
REQ-004 The FSM shall have the states IDLE, IFU_BUSY and LSU_BUSY.
REQ-005 In IDLE, a grant shall be combinational in the request cycle: ifu_gnt or lsu_gnt, never both.
REQ-006 Grants shall occur only in IDLE with ecl_flush low.
REQ-007 Priority:
- LSU wins by default.
- IFU wins when ifu_req=1 and starve_cnt==STARVE_MAX.
REQ-008 starve_cnt (3 bits) shall count as follows:
- Increment on an LSU grant while ifu_req=1.
- Clear on an IFU grant, or on an LSU grant with ifu_req=0.
- Saturate at STARVE_MAX.
REQ-009 On a grant, the request's we, addr, wdata and wstrb shall be latched.
- IFU requests latch we=0 and wstrb=0.
- The state moves to the matching BUSY state on the next edge.
REQ-010 bus_req shall be 1 exactly in the BUSY states, with bus_* driven from the latched values and held stable.
REQ-011 In a BUSY state, bus_ack or bus_err sampled high shall return the FSM to IDLE on that edge.
REQ-012 The response pulse shall be registered and asserted for 1 cycle, the cycle after completion:
- IFU, ack: ifu_rdata_vld.
- IFU, error: ifu_buserr.
- LSU load, ack: lsu_data_valid.
- LSU store, ack: lsu_wr_fin.
- LSU, error: lsu_buserr.
REQ-013 rdata shall be captured from bus_rdata at completion and held until the next completion.
REQ-014 When bus_ack and bus_err are both high, bus_err shall take precedence.
REQ-015 A new grant shall be possible in the same cycle as the response pulse, since the FSM is in IDLE.
- Minimum grant-to-grant spacing is therefore 3 cycles with a 1-cycle slave.
REQ-016 The timeout counter shall work as follows:
- 8 bits, cleared on entering a BUSY state, incremented each BUSY cycle without completion.
- When it reaches TIMEOUT, it shall force completion as bus_err: FSM to IDLE, the error pulse follows.
REQ-017 Flush handling:
- ecl_flush during IFU_BUSY shall mark the fetch killed.
- The bus transaction shall still complete, with no ifu_rdata_vld or ifu_buserr pulse.
- LSU transactions shall not be affected by flush.
REQ-018 Requests while busy or flushed shall see no grant, and the requester shall hold its request.
REQ-019 The kill mark shall clear on entry to IDLE.

Reset
REQ-020 On resetn low, the following shall reset asynchronously:
- FSM to IDLE.
- bus_req, all gnt and all pulse outputs to 0.
- rdata, latched fields, starve_cnt, timeout counter and kill mark to 0.
REQ-021 Reset mid-transaction shall abandon it with no response pulse.

Verification
REQ-022 Simultaneous ifu_req and lsu_req in IDLE:
- lsu_gnt=1, ifu_gnt=0.
- bus_req=1 with bus_addr=lsu_addr next cycle.
REQ-023 LSU load of 0x100, bus_ack one cycle after bus_req with bus_rdata=0xDEADBEEF:
- lsu_data_valid pulses 1 cycle with lsu_rdata=0xDEADBEEF.
- Grant to lsu_data_valid takes 3 cycles.
REQ-024 Store with wstrb=4'b0011 and bus_err=bus_ack=1 at completion:
- lsu_buserr pulses, lsu_wr_fin stays 0.
REQ-025 ifu_req held, lsu_req held for 5 back-to-back grants:
- LSU granted 4 times, then ifu_gnt=1.
REQ-026 IFU fetch, ecl_flush pulsed during IFU_BUSY, then bus_ack:
- No ifu_rdata_vld pulse.
- FSM returns to IDLE.
- Next grant accepted.
REQ-027 TIMEOUT=8, slave never acks:
- bus_req high 8 cycles, then drops.
- The requester's buserr pulses once.

Source files
------------

// File: rtl/c7bexu_biu_arb.sv
// Bus interface arbiter: shares one memory port between IFU fetches and LSU
// loads/stores. At most one transaction is outstanding, with starvation guard and timeout.
module c7bexu_biu_arb #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rdata_vld,
    output logic [31:0] ifu_rdata,
    output logic        ifu_buserr,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_gnt,
    output logic        lsu_data_valid,
    output logic        lsu_wr_fin,
    output logic [31:0] lsu_rdata,
    output logic        lsu_buserr,
    input  logic        ecl_flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IFU_BUSY = 2'd1,
        LSU_BUSY = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            kill_q, kill_d;
    logic            ifu_vld_q, ifu_vld_d;
    logic            ifu_err_q, ifu_err_d;
    logic            lsu_dv_q, lsu_dv_d;
    logic            lsu_fin_q, lsu_fin_d;
    logic            lsu_err_q, lsu_err_d;
    logic            ifu_gnt_c, lsu_gnt_c;
    logic            slave_done, tmo_hit, cpl, cpl_err, killed;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, grant and response decode
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        kill_d     = kill_q;
        ifu_vld_d  = 1'b0;
        ifu_err_d  = 1'b0;
        lsu_dv_d   = 1'b0;
        lsu_fin_d  = 1'b0;
        lsu_err_d  = 1'b0;
        ifu_gnt_c  = 1'b0;
        lsu_gnt_c  = 1'b0;
        slave_done = bus_ack | bus_err;
        tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
        cpl        = slave_done | tmo_hit;
        // A timeout with no slave response is reported as an error
        cpl_err    = bus_err | ~slave_done;
        killed     = kill_q | ecl_flush;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (!ecl_flush) begin
                    if (lsu_req && !(ifu_req && (starve_q == CW'(STARVE_MAX)))) begin
                        lsu_gnt_c = 1'b1;
                        state_d   = LSU_BUSY;
                        we_d      = lsu_we;
                        addr_d    = lsu_addr;
                        wdata_d   = lsu_wdata;
                        wstrb_d   = lsu_wstrb;
                        tmo_d     = '0;
                        if (!ifu_req) begin
                            starve_d = '0;
                        end else if (starve_q < CW'(STARVE_MAX)) begin
                            starve_d = starve_q + CW'(1);
                        end
                    end else if (ifu_req) begin
                        ifu_gnt_c = 1'b1;
                        state_d   = IFU_BUSY;
                        we_d      = 1'b0;
                        addr_d    = ifu_addr;
                        wdata_d   = '0;
                        wstrb_d   = '0;
                        tmo_d     = '0;
                        starve_d  = '0;
                    end
                end
            end
            IFU_BUSY: begin
                if (cpl) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (slave_done) begin
                        rdata_d = bus_rdata;
                    end
                    if (!killed) begin
                        ifu_vld_d = ~cpl_err;
                        ifu_err_d = cpl_err;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (ecl_flush) begin
                        kill_d = 1'b1;
                    end
                end
            end
            LSU_BUSY: begin
                if (cpl) begin
                    state_d   = IDLE;
                    kill_d    = 1'b0;
                    if (slave_done) begin
                        rdata_d = bus_rdata;
                    end
                    lsu_err_d = cpl_err;
                    lsu_dv_d  = ~cpl_err & ~we_q;
                    lsu_fin_d = ~cpl_err & we_q;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latched request fields, counters and response pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            starve_q  <= '0;
            tmo_q     <= '0;
            kill_q    <= 1'b0;
            ifu_vld_q <= 1'b0;
            ifu_err_q <= 1'b0;
            lsu_dv_q  <= 1'b0;
            lsu_fin_q <= 1'b0;
            lsu_err_q <= 1'b0;
        end else begin
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            kill_q    <= kill_d;
            ifu_vld_q <= ifu_vld_d;
            ifu_err_q <= ifu_err_d;
            lsu_dv_q  <= lsu_dv_d;
            lsu_fin_q <= lsu_fin_d;
            lsu_err_q <= lsu_err_d;
        end
    end

    assign ifu_gnt        = ifu_gnt_c;
    assign lsu_gnt        = lsu_gnt_c;
    assign bus_req        = (state_q != IDLE);
    assign bus_we         = we_q;
    assign bus_addr       = addr_q;
    assign bus_wdata      = wdata_q;
    assign bus_wstrb      = wstrb_q;
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;
    assign ifu_rdata_vld  = ifu_vld_q;
    assign ifu_buserr     = ifu_err_q;
    assign lsu_data_valid = lsu_dv_q;
    assign lsu_wr_fin     = lsu_fin_q;
    assign lsu_buserr     = lsu_err_q;

endmodule
